// File: rtl/ysyx_pkg.sv
// rtl/ysyx_pkg.sv - shared sequencer states and reset constants for the ysyx core
package ysyx_pkg;

    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_IWAIT = 3'd1,
        ST_EXEC  = 3'd2,
        ST_MREQ  = 3'd3,
        ST_MWAIT = 3'd4,
        ST_WB    = 3'd5,
        ST_HALT  = 3'd6
    } state_t;

    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ysyx_perf_cnt.sv
// rtl/ysyx_perf_cnt.sv - free-running cycle and retired-instruction counter pair
module ysyx_perf_cnt #(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cycle_en,
    input  logic             retire,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (cycle_en) cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (retire)   instret_cnt <= instret_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ysyx_step_ctrl.sv
// rtl/ysyx_step_ctrl.sv - handshake-driven multi-cycle sequencer; YSYX_STEP_PERF_EN adds perf counters
module ysyx_step_ctrl
    import ysyx_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC)
`ifdef YSYX_STEP_PERF_EN
    , parameter int             CNT_W    = 64
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             ifu_req_valid,
    input  logic             ifu_req_ready,
    output logic [WIDTH-1:0] ifu_addr,
    input  logic             ifu_resp_valid,
    input  logic [31:0]      ifu_resp_inst,
    input  logic             ifu_resp_err,
    output logic [31:0]      inst,
    input  logic             dec_mem_re,
    input  logic             dec_mem_we,
    input  logic             dec_rd_we,
    input  logic             dec_csr_we,
    input  logic             dec_halt,
    input  logic [WIDTH-1:0] pc_next,
    output logic             lsu_req_valid,
    input  logic             lsu_req_ready,
    output logic             lsu_req_we,
    input  logic             lsu_resp_valid,
    input  logic             lsu_resp_err,
    output logic [WIDTH-1:0] pc,
    output logic             rf_we,
    output logic             csr_we,
    output logic             commit,
    output logic             halted,
    output logic             fault
`ifdef YSYX_STEP_PERF_EN
    , output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
`endif
);

    state_t state;

    // Request valids are pure state decodes so a request is up in the very first cycle after reset.
    assign ifu_req_valid = (state == ST_FETCH);
    assign lsu_req_valid = (state == ST_MREQ);
    assign ifu_addr      = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_FETCH;
            pc         <= RESET_PC;
            inst       <= NOP_INST;
            lsu_req_we <= 1'b0;
            rf_we      <= 1'b0;
            csr_we     <= 1'b0;
            commit     <= 1'b0;
            halted     <= 1'b0;
            fault      <= 1'b0;
        end else begin
            commit <= 1'b0;
            rf_we  <= 1'b0;
            csr_we <= 1'b0;
            case (state)
                ST_FETCH: begin
                    if (ifu_req_ready) state <= ST_IWAIT;
                end
                ST_IWAIT: begin
                    if (ifu_resp_valid) begin
                        inst <= ifu_resp_inst;
                        if (ifu_resp_err) begin
                            fault  <= 1'b1;
                            halted <= 1'b1;
                            state  <= ST_HALT;
                        end else begin
                            state <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    if (dec_halt) begin
                        halted <= 1'b1;
                        state  <= ST_HALT;
                    end else if (dec_mem_re || dec_mem_we) begin
                        lsu_req_we <= dec_mem_we;
                        state      <= ST_MREQ;
                    end else begin
                        commit <= 1'b1;
                        rf_we  <= dec_rd_we;
                        csr_we <= dec_csr_we;
                        state  <= ST_WB;
                    end
                end
                ST_MREQ: begin
                    if (lsu_req_ready) state <= ST_MWAIT;
                end
                ST_MWAIT: begin
                    if (lsu_resp_valid) begin
                        if (lsu_resp_err) begin
                            fault  <= 1'b1;
                            halted <= 1'b1;
                            state  <= ST_HALT;
                        end else begin
                            // Decode is still driven by the held inst; a store never writes rd.
                            commit <= 1'b1;
                            rf_we  <= dec_rd_we & ~dec_mem_we;
                            csr_we <= dec_csr_we;
                            state  <= ST_WB;
                        end
                    end
                end
                ST_WB: begin
                    pc         <= pc_next;
                    lsu_req_we <= 1'b0;
                    state      <= ST_FETCH;
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state <= ST_FETCH;
                end
            endcase
        end
    end

`ifdef YSYX_STEP_PERF_EN
    ysyx_perf_cnt #(
        .CNT_W(CNT_W)
    ) u_perf_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .cycle_en   (state != ST_HALT),
        .retire     (commit),
        .cycle_cnt  (cycle_cnt),
        .instret_cnt(instret_cnt)
    );
`endif

endmodule

// File: tb/tb_ysyx_step_ctrl.sv
// tb/tb_ysyx_step_ctrl.sv - directed and randomized bench for ysyx_step_ctrl with a timing-based reference model
module tb_ysyx_step_ctrl;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] ADDI   = 32'h0010_0093;
    localparam logic [31:0] LOADI  = 32'h0000_0084;
    localparam logic [31:0] STOREI = 32'h0000_0085;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ifu_req_valid, ifu_req_ready;
    logic [31:0] ifu_addr;
    logic        ifu_resp_valid, ifu_resp_err;
    logic [31:0] ifu_resp_inst, inst;
    logic        dec_mem_re, dec_mem_we, dec_rd_we, dec_csr_we, dec_halt;
    logic [31:0] pc_next, pc;
    logic        lsu_req_valid, lsu_req_ready, lsu_req_we;
    logic        lsu_resp_valid, lsu_resp_err;
    logic        rf_we, csr_we, commit, halted, fault;
`ifdef YSYX_STEP_PERF_EN
    logic [63:0] cycle_cnt, instret_cnt;
`endif

    always #5 clk = ~clk;

    // Bench-side IDU: kind in inst[2:0] (4 load, 5 store, 6 re+we store), rd_we inst[7], csr_we inst[8].
    function automatic logic [31:0] next_pc(input logic [31:0] i, input logic [31:0] p);
        return p + 32'd4 + (i[9] ? {22'd0, i[31:24], 2'b00} : 32'd0);
    endfunction

    assign dec_halt   = (inst == EBREAK);
    assign dec_mem_re = !dec_halt && (inst[2:0] == 3'd4 || inst[2:0] == 3'd6);
    assign dec_mem_we = !dec_halt && (inst[2:0] == 3'd5 || inst[2:0] == 3'd6);
    assign dec_rd_we  = inst[7];
    assign dec_csr_we = inst[8];
    assign pc_next    = next_pc(inst, pc);

    ysyx_step_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_inst(ifu_resp_inst), .ifu_resp_err(ifu_resp_err),
        .inst(inst),
        .dec_mem_re(dec_mem_re), .dec_mem_we(dec_mem_we), .dec_rd_we(dec_rd_we),
        .dec_csr_we(dec_csr_we), .dec_halt(dec_halt), .pc_next(pc_next),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_we(lsu_req_we),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_err(lsu_resp_err),
        .pc(pc), .rf_we(rf_we), .csr_we(csr_we), .commit(commit), .halted(halted), .fault(fault)
`ifdef YSYX_STEP_PERF_EN
        , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // Model: absolute cycle numbers at which each observable event must happen.
    int fetch_at, lsu_at, commit_at, halt_at;
    logic h_fault, w_rf, w_csr, m_store;
    logic [31:0] m_pc, m_inst;
    logic [63:0] m_cyc, m_ret;
    logic [31:0] f_inst;
    logic f_err, l_err;
    logic i_pend, l_pend;
    int i_hs, i_start, l_hs, l_start;
    logic [32:0] script[$];
    logic fast, rand_mode;
    int rdy_low, ldelay;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic get_inst(output logic [31:0] i, output logic e);
        logic [32:0] v;
        logic [31:0] r;
        int unsigned k;
        if (script.size() > 0) begin
            v = script.pop_front();
            i = v[31:0];
            e = v[32];
        end else if (rand_mode) begin
            r = $urandom;
            k = $urandom_range(0, 15);
            if (k == 0)      i = EBREAK;
            else if (k <= 3) i = {r[31:3], 3'd4};
            else if (k <= 6) i = {r[31:3], (k == 6) ? 3'd6 : 3'd5};
            else             i = {r[31:3], 3'(k & 3)};
            e = ($urandom_range(0, 63) == 0);
        end else begin
            i = EBREAK;
            e = 1'b0;
        end
    endtask

    task automatic step();
        logic e_iv, e_lv, e_cm, e_h, is_mem, is_st;
        e_iv = (fetch_at >= 0) && (cyc >= fetch_at);
        e_lv = (lsu_at >= 0) && (cyc >= lsu_at);
        e_cm = (cyc == commit_at);
        e_h  = (halt_at >= 0) && (cyc >= halt_at);
        chk("ifu_req_valid", 64'(ifu_req_valid), 64'(e_iv));
        chk("lsu_req_valid", 64'(lsu_req_valid), 64'(e_lv));
        chk("commit", 64'(commit), 64'(e_cm));
        chk("rf_we", 64'(rf_we), 64'(e_cm & w_rf));
        chk("csr_we", 64'(csr_we), 64'(e_cm & w_csr));
        chk("halted", 64'(halted), 64'(e_h));
        chk("fault", 64'(fault), 64'(e_h & h_fault));
        chk("pc", 64'(pc), 64'(m_pc));
        chk("inst", 64'(inst), 64'(m_inst));
        if (e_iv) chk("ifu_addr", 64'(ifu_addr), 64'(m_pc));
        if (e_lv) chk("lsu_req_we", 64'(lsu_req_we), 64'(m_store));
`ifdef YSYX_STEP_PERF_EN
        chk("cycle_cnt", cycle_cnt, m_cyc);
        chk("instret_cnt", instret_cnt, m_ret);
`endif
        if (!e_h) m_cyc++;
        if (e_cm) begin
            m_ret++;
            m_pc = next_pc(m_inst, m_pc);
            fetch_at = cyc + 1;
            commit_at = -1;
        end
        // instruction memory
        if (rdy_low > 0) begin
            ifu_req_ready = 1'b0;
            rdy_low--;
        end else begin
            ifu_req_ready = fast ? 1'b1 : ($urandom_range(0, 2) != 0);
        end
        if (e_iv && ifu_req_ready) begin
            fetch_at = -1;
            get_inst(f_inst, f_err);
            i_hs = cyc;
            i_start = cyc + (fast ? 0 : int'($urandom_range(0, 3)));
            i_pend = 1'b1;
        end
        ifu_resp_valid = i_pend && (cyc >= i_start);
        ifu_resp_inst  = ifu_resp_valid ? f_inst : $urandom;
        ifu_resp_err   = ifu_resp_valid ? f_err : 1'($urandom);
        if (ifu_resp_valid && cyc > i_hs) begin
            i_pend = 1'b0;
            m_inst = f_inst;
            is_st  = (f_inst != EBREAK) && (f_inst[2:0] == 3'd5 || f_inst[2:0] == 3'd6);
            is_mem = is_st || ((f_inst != EBREAK) && f_inst[2:0] == 3'd4);
            w_csr  = f_inst[8];
            w_rf   = f_inst[7] & ~is_st;
            if (f_err) begin
                halt_at = cyc + 1;
                h_fault = 1'b1;
            end else if (f_inst == EBREAK) begin
                halt_at = cyc + 2;
                h_fault = 1'b0;
            end else if (is_mem) begin
                lsu_at = cyc + 2;
                m_store = is_st;
            end else begin
                commit_at = cyc + 2;
            end
        end
        // data memory
        lsu_req_ready = fast ? 1'b1 : ($urandom_range(0, 2) != 0);
        if (e_lv && lsu_req_ready) begin
            lsu_at = -1;
            l_hs = cyc;
            l_start = cyc + ((ldelay >= 0) ? ldelay : (fast ? 0 : int'($urandom_range(0, 4))));
            l_err = !fast && ($urandom_range(0, 31) == 0);
            l_pend = 1'b1;
        end
        lsu_resp_valid = l_pend && (cyc >= l_start);
        lsu_resp_err   = lsu_resp_valid ? l_err : 1'($urandom);
        if (lsu_resp_valid && cyc > l_hs) begin
            l_pend = 1'b0;
            if (l_err) begin
                halt_at = cyc + 1;
                h_fault = 1'b1;
            end else begin
                commit_at = cyc + 1;
            end
        end
        cyc++;
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst pc", 64'(pc), 64'(RST_PC));
        chk("rst inst", 64'(inst), 64'(NOP));
        chk("rst strobes", {61'd0, commit, rf_we, csr_we}, 64'd0);
        chk("rst halted/fault", {62'd0, halted, fault}, 64'd0);
        chk("rst lsu_req_valid", 64'(lsu_req_valid), 64'd0);
`ifdef YSYX_STEP_PERF_EN
        chk("rst counters", cycle_cnt | instret_cnt, 64'd0);
`endif
        ifu_req_ready = 1'b0; ifu_resp_valid = 1'b0; ifu_resp_err = 1'b0; ifu_resp_inst = 32'd0;
        lsu_req_ready = 1'b0; lsu_resp_valid = 1'b0; lsu_resp_err = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        fetch_at = 1; lsu_at = -1; commit_at = -1; halt_at = -1;
        h_fault = 1'b0; w_rf = 1'b0; w_csr = 1'b0; m_store = 1'b0;
        m_pc = RST_PC; m_inst = NOP; m_cyc = 64'd0; m_ret = 64'd0;
        i_pend = 1'b0; l_pend = 1'b0; i_hs = 0; i_start = 0; l_hs = 0; l_start = 0;
        script.delete();
        fast = 1'b0; rand_mode = 1'b0; rdy_low = 0; ldelay = -1;
        cyc = 1;
        #1;
    endtask

    initial begin
        @(negedge clk);
        #1;
        // addi then ebreak, zero-wait memories
        do_reset();
        fast = 1'b1;
        script.push_back({1'b0, ADDI});
        script.push_back({1'b0, EBREAK});
        for (int n = 0; n < 10; n++) begin
            if (cyc == 4) chk("s1 commit at 4", 64'(commit), 64'd1);
            if (cyc == 5) chk("s1 pc at 5", 64'(pc), 64'h8000_0004);
            if (cyc == 7) chk("s1 running in exec", 64'(halted), 64'd0);
            if (cyc == 8) chk("s1 halted at 8", 64'(halted), 64'd1);
            step();
        end
        // fetch ready held low three cycles
        do_reset();
        fast = 1'b1; rdy_low = 3;
        script.push_back({1'b0, ADDI});
        for (int n = 0; n < 10; n++) begin
            if (cyc == 4) chk("s2 valid held", {31'd0, ifu_req_valid, ifu_addr}, {31'd0, 1'b1, RST_PC});
            if (cyc == 6) chk("s2 no early commit", 64'(commit), 64'd0);
            if (cyc == 7) chk("s2 commit at 7", 64'(commit), 64'd1);
            step();
        end
        // load with a five-cycle data response
        do_reset();
        fast = 1'b1; ldelay = 5;
        script.push_back({1'b0, LOADI});
        for (int n = 0; n < 14; n++) begin
            if (cyc == 9)  chk("s3 rf_we before resp", 64'(rf_we), 64'd0);
            if (cyc == 10) chk("s3 rf_we after resp", 64'(rf_we), 64'd1);
            if (cyc == 11) chk("s3 pc advanced once", 64'(pc), 64'h8000_0004);
            step();
        end
        // store with rd bit set
        do_reset();
        fast = 1'b1;
        script.push_back({1'b0, STOREI});
        for (int n = 0; n < 10; n++) begin
            if (cyc == 4) chk("s4 store req", {62'd0, lsu_req_valid, lsu_req_we}, 64'd3);
            if (cyc == 6) chk("s4 wb commit/rf_we", {62'd0, commit, rf_we}, 64'd2);
            step();
        end
        // fetch bus error
        do_reset();
        fast = 1'b1;
        script.push_back({1'b1, ADDI});
        for (int n = 0; n < 8; n++) begin
            if (cyc == 3) chk("s5 fault+halted", {62'd0, fault, halted}, 64'd3);
            if (cyc == 6) chk("s5 pc frozen", 64'(pc), 64'(RST_PC));
            step();
        end
        // reset while waiting on a load response
        do_reset();
        fast = 1'b1; ldelay = 5;
        script.push_back({1'b0, LOADI});
        for (int n = 0; n < 6; n++) step();
        chk("s6 in mwait", {62'd0, lsu_req_valid, halted}, 64'd0);
        do_reset();
        fast = 1'b1;
        for (int n = 0; n < 6; n++) step();
`ifdef YSYX_STEP_PERF_EN
        do_reset();
        fast = 1'b1;
        for (int n = 0; n < 10; n++) script.push_back({1'b0, ADDI});
        script.push_back({1'b0, EBREAK});
        for (int n = 0; n < 60; n++) step();
        chk("perf instret=10", instret_cnt, 64'd10);
`endif
        // randomized traffic with resets after each halt
        do_reset();
        rand_mode = 1'b1;
        for (int n = 0; n < 4000; n++) begin
            step();
            if (halt_at >= 0 && cyc > halt_at + 2) begin
                do_reset();
                rand_mode = 1'b1;
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
